// File: rtl/rtlfuzz_pkg.sv
// rtlfuzz_pkg: shared constants and UART state type for the commit monitor
package rtlfuzz_pkg;
    localparam logic [6:0]  OPC_SYSTEM   = 7'h73;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [31:0] FINISH_JSELF = 32'h0000006f;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 LSB-first receiver (clk_i, rst_ni, rx_i -> data_o, valid_o, err_o strobes)
module uart_rx_8n1 import rtlfuzz_pkg::*; #(
    parameter int DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       err_o
);
    localparam int CW = $clog2(DIV + 1);
    uart_state_e   state_q;
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          rx_s;
    assign rx_s = sync_q[1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rx_i};
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            cnt_q   <= (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
            case (state_q)
                IDLE: if (sync_q[2] && !rx_s) begin
                    state_q <= START;
                    cnt_q   <= CW'(DIV / 2 - 1);
                end
                START: if (cnt_q == '0) begin
                    state_q <= rx_s ? IDLE : DATA;
                    cnt_q   <= CW'(DIV - 1);
                    bit_q   <= '0;
                end
                DATA: if (cnt_q == '0) begin
                    shift_q[bit_q] <= rx_s;
                    cnt_q          <= CW'(DIV - 1);
                    bit_q          <= bit_q + 1'b1;
                    state_q        <= (bit_q == 3'd7) ? STOP : DATA;
                end
                STOP: if (cnt_q == '0) begin
                    valid_o <= rx_s;
                    err_o   <= !rx_s;
                    data_o  <= rx_s ? shift_q : data_o;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/rtlfuzz_commit_monitor.sv
// rtlfuzz_commit_monitor: retirement-trace monitor (finish/mstatus/commit_count) plus console UART receiver
module rtlfuzz_commit_monitor import rtlfuzz_pkg::*; #(
    parameter logic [31:0] FINISH_INSN = FINISH_JSELF,
    parameter int          HARTID_W    = 1,
    parameter int          CLK_HZ      = 100_000_000,
    parameter int          BAUD        = 115200
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid,
    input  logic [HARTID_W-1:0] hartid,
    input  logic [39:0]         pc,
    input  logic [31:0]         inst,
    input  logic [63:0]         wdata,
    output logic [63:0]         mstatus,
    output logic                finish,
    output logic [63:0]         commit_count,
    input  logic                uart_srx,
    output logic                uart_stx,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    output logic                rx_err
);
    localparam int DIV = CLK_HZ / BAUD;
    logic csr_rd;
    logic unused_trace;
    assign unused_trace = ^{hartid, pc};
    // funct3 in {1,2,3,5,6,7} is exactly funct3[1:0] != 0
    assign csr_rd = inst[6:0] == OPC_SYSTEM && inst[13:12] != 2'b00 &&
                    inst[31:20] == CSR_MSTATUS && inst[11:7] != 5'd0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mstatus      <= '0;
            finish       <= 1'b0;
            commit_count <= '0;
            uart_stx     <= 1'b1;
        end else begin
            uart_stx <= 1'b1;
            if (valid) begin
                commit_count <= commit_count + 64'd1;
                finish       <= finish || inst == FINISH_INSN;
                mstatus      <= csr_rd ? wdata : mstatus;
            end
        end
    end
    uart_rx_8n1 #(.DIV(DIV)) u_rx (
        .clk_i   (clock),
        .rst_ni  (reset),
        .rx_i    (uart_srx),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .err_o   (rx_err)
    );
endmodule

// File: tb/tb_rtlfuzz_commit_monitor.sv
// tb_rtlfuzz_commit_monitor: directed self-checking bench for the commit monitor and UART receiver
module tb_rtlfuzz_commit_monitor;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [0:0]  hartid = '0;
    logic [39:0] pc = '0;
    logic [31:0] inst = '0;
    logic [63:0] wdata = '0;
    logic [63:0] mstatus;
    logic        finish;
    logic [63:0] commit_count;
    logic        uart_srx = 1'b1;
    logic        uart_stx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    int          checks = 0;
    int          failures = 0;
    int          nv = 0;
    int          ne = 0;
    logic [7:0]  got [8];

    rtlfuzz_commit_monitor #(.CLK_HZ(16), .BAUD(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .valid        (valid),
        .hartid       (hartid),
        .pc           (pc),
        .inst         (inst),
        .wdata        (wdata),
        .mstatus      (mstatus),
        .finish       (finish),
        .commit_count (commit_count),
        .uart_srx     (uart_srx),
        .uart_stx     (uart_stx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_err       (rx_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid) begin
            if (nv < 8) got[nv] = rx_data;
            nv++;
        end
        if (rx_err) ne++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic commit(input logic [31:0] i, input logic [63:0] d);
        @(negedge clock);
        valid = 1'b1;
        inst  = i;
        wdata = d;
        pc    = pc + 40'd4;
        @(negedge clock);
        valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        uart_srx = b;
        repeat (16) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(b[k]);
        send_bit(stop_bit);
        uart_srx = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cnt"}, commit_count, 64'd0);
        chk({tag, "_mst"}, mstatus, 64'd0);
        chk({tag, "_fin"}, {63'd0, finish}, 64'd0);
        chk({tag, "_stx"}, {63'd0, uart_stx}, 64'd1);
        chk({tag, "_rxd"}, {56'd0, rx_data}, 64'd0);
        chk({tag, "_rxv"}, {63'd0, rx_valid}, 64'd0);
        chk({tag, "_rxe"}, {63'd0, rx_err}, 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_reset_vals("in_rst");
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk_reset_vals("idle");
        end

        for (int c = 0; c < 5; c++) commit(32'h00000013, 64'd0);
        chk("cnt5", commit_count, 64'd5);
        chk("fin5", {63'd0, finish}, 64'd0);
        commit(32'h0000006f, 64'd0);
        chk("cnt6", commit_count, 64'd6);
        chk("fin6", {63'd0, finish}, 64'd1);
        for (int c = 0; c < 3; c++) commit(32'h00000013, 64'd0);
        chk("cnt9", commit_count, 64'd9);
        chk("fin9", {63'd0, finish}, 64'd1);
        repeat (2) @(negedge clock);
        chk("cnt_idle", commit_count, 64'd9);

        commit(32'h300022f3, 64'h8000000A00006080);
        chk("mst_rd", mstatus, 64'h8000000A00006080);
        chk("cnt10", commit_count, 64'd10);
        commit(32'h30002073, 64'd1);
        chk("mst_rd0", mstatus, 64'h8000000A00006080);
        commit(32'h300042f3, 64'd2);
        chk("mst_f3_4", mstatus, 64'h8000000A00006080);
        commit(32'h301022f3, 64'd3);
        chk("mst_misa", mstatus, 64'h8000000A00006080);
        commit(32'h3002f2f3, 64'h55);
        chk("mst_csrrci", mstatus, 64'h55);
        chk("cnt14", commit_count, 64'd14);

        send_frame(8'h41, 1'b1);
        repeat (8) @(negedge clock);
        chk("f41_nv", nv, 1);
        chk("f41_ne", ne, 0);
        chk("f41_got", {56'd0, got[0]}, 64'h41);
        chk("f41_rxd", {56'd0, rx_data}, 64'h41);

        send_frame(8'h0A, 1'b1);
        send_frame(8'h55, 1'b1);
        repeat (8) @(negedge clock);
        chk("b2b_nv", nv, 3);
        chk("b2b_got1", {56'd0, got[1]}, 64'h0A);
        chk("b2b_got2", {56'd0, got[2]}, 64'h55);
        chk("b2b_ne", ne, 0);

        send_frame(8'hC3, 1'b0);
        repeat (8) @(negedge clock);
        chk("ferr_ne", ne, 1);
        chk("ferr_nv", nv, 3);
        chk("ferr_rxd", {56'd0, rx_data}, 64'h55);

        uart_srx = 1'b0;
        repeat (3) @(negedge clock);
        uart_srx = 1'b1;
        repeat (40) @(negedge clock);
        chk("glitch_nv", nv, 3);
        chk("glitch_ne", ne, 1);
        send_frame(8'h3C, 1'b1);
        repeat (8) @(negedge clock);
        chk("post_glitch_nv", nv, 4);
        chk("post_glitch_got", {56'd0, got[3]}, 64'h3C);

        commit(32'h00000013, 64'd0);
        chk("cnt15", commit_count, 64'd15);
        uart_srx = 1'b0;
        repeat (80) @(negedge clock);
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        uart_srx = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (200) @(negedge clock);
        chk("abort_nv", nv, 4);
        chk("abort_ne", ne, 1);
        send_frame(8'hA5, 1'b1);
        repeat (8) @(negedge clock);
        chk("after_rst_nv", nv, 5);
        chk("after_rst_got", {56'd0, got[4]}, 64'hA5);
        chk("after_rst_rxd", {56'd0, rx_data}, 64'hA5);
        chk("after_rst_cnt", commit_count, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
